// File: rtl/fetch_sequencer_if.sv
// fetch_sequencer_if: bundles the sequencer's control, ROM and processor signals.
//   start, stop      control levels from the host
//   step             single-step advance (only when FETCH_STEP_EN is defined)
//   mem_q            ROM read data
//   proc_done        processor completion
//   mem_addr         ROM address (= PC)
//   instr            latched instruction
//   run              one-cycle issue pulse to the processor
//   busy, halted     status
//   retired          saturating retired-instruction count
// Modports: master = the sequencer, slave = the surrounding system.
interface fetch_sequencer_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 16
);
  logic              start;
  logic              stop;
`ifdef FETCH_STEP_EN
  logic              step;
`endif
  logic [DATA_W-1:0] mem_q;
  logic              proc_done;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] instr;
  logic              run;
  logic              busy;
  logic              halted;
  logic [15:0]       retired;

`ifdef FETCH_STEP_EN
  modport master (
    input  start, stop, step, mem_q, proc_done,
    output mem_addr, instr, run, busy, halted, retired
  );
  modport slave (
    output start, stop, step, mem_q, proc_done,
    input  mem_addr, instr, run, busy, halted, retired
  );
`else
  modport master (
    input  start, stop, mem_q, proc_done,
    output mem_addr, instr, run, busy, halted, retired
  );
  modport slave (
    output start, stop, mem_q, proc_done,
    input  mem_addr, instr, run, busy, halted, retired
  );
`endif
endinterface

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: gates instruction fetch by execution. Drives the ROM address,
// captures the fetched word, issues it with a one-cycle run pulse, waits for
// proc_done, then retires it and advances the PC (or halts / returns to idle).
// Ports:
//   clock   single clock, rising edge
//   resetN  asynchronous active-low reset
//   bus     fetch_sequencer_if.master (start/stop/[step]/mem_q/proc_done in;
//           mem_addr/instr/run/busy/halted/retired out)
// Parameters: ADDR_W (PC width, wraps), DATA_W (instruction width),
//   MEM_LAT (ROM read latency, >=1), HALT_OP (opcode in instr[DATA_W-1 -: 3]).
// Optional feature: define FETCH_STEP_EN to add the step input and a PAUSE state
// entered after every non-halt retire without stop; step advances, stop exits.
module fetch_sequencer #(
  parameter int         ADDR_W  = 5,
  parameter int         DATA_W  = 16,
  parameter int         MEM_LAT = 1,
  parameter logic [2:0] HALT_OP = 3'b111
) (
  input logic              clock,
  input logic              resetN,
  fetch_sequencer_if.master bus
);

  localparam int LAT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(MEM_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LATCH,
    S_ISSUE,
    S_EXEC,
`ifdef FETCH_STEP_EN
    S_HALT,
    S_PAUSE
`else
    S_HALT
`endif
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic [DATA_W-1:0] instr_r;
  logic [LAT_W-1:0]  lat_cnt;
  logic              run_r;
  logic              busy_r;
  logic              halted_r;
  logic [15:0]       retired_r;
  logic              is_halt;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign is_halt = (instr_r[DATA_W-1 -: 3] == HALT_OP);

  // Sequencer FSM; every output is a register updated with the state transition.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state     <= S_IDLE;
      pc        <= '0;
      instr_r   <= '0;
      lat_cnt   <= '0;
      run_r     <= 1'b0;
      busy_r    <= 1'b0;
      halted_r  <= 1'b0;
      retired_r <= '0;
    end else begin
      run_r <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            pc      <= '0;
            lat_cnt <= '0;
            busy_r  <= 1'b1;
            state   <= S_FETCH;
          end
        end
        // Hold the address for MEM_LAT cycles so mem_q is valid in LATCH.
        S_FETCH: begin
          if (lat_cnt == LAT_LAST) begin
            state <= S_LATCH;
          end else begin
            lat_cnt <= lat_cnt + 1'b1;
          end
        end
        // run is raised here so that it is high during the ISSUE cycle.
        S_LATCH: begin
          instr_r <= bus.mem_q;
          run_r   <= 1'b1;
          state   <= S_ISSUE;
        end
        S_ISSUE: begin
          state <= S_EXEC;
        end
        S_EXEC: begin
          if (bus.proc_done) begin
            retired_r <= sat_inc(retired_r);
            if (is_halt) begin
              busy_r   <= 1'b0;
              halted_r <= 1'b1;
              state    <= S_HALT;
            end else if (bus.stop) begin
              busy_r <= 1'b0;
              state  <= S_IDLE;
            end else begin
`ifdef FETCH_STEP_EN
              state <= S_PAUSE;
`else
              pc      <= pc + 1'b1;
              lat_cnt <= '0;
              state   <= S_FETCH;
`endif
            end
          end
        end
`ifdef FETCH_STEP_EN
        // stop wins when both stop and step are high.
        S_PAUSE: begin
          if (bus.stop) begin
            busy_r <= 1'b0;
            state  <= S_IDLE;
          end else if (bus.step) begin
            pc      <= pc + 1'b1;
            lat_cnt <= '0;
            state   <= S_FETCH;
          end
        end
`endif
        // Terminal: only resetN leaves HALT.
        S_HALT: begin
          state <= S_HALT;
        end
        default: begin
          busy_r <= 1'b0;
          state  <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.mem_addr = pc;
  assign bus.instr    = instr_r;
  assign bus.run      = run_r;
  assign bus.busy     = busy_r;
  assign bus.halted   = halted_r;
  assign bus.retired  = retired_r;

endmodule

// File: tb/tb_fetch_sequencer.sv
module tb_fetch_sequencer;

  logic clock = 1'b0;
  logic resetN;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   runs2 = 0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  fetch_sequencer_if #(.ADDR_W(5), .DATA_W(16)) bus ();
  fetch_sequencer_if #(.ADDR_W(2), .DATA_W(16)) bus2 ();

  fetch_sequencer #(.ADDR_W(5), .DATA_W(16), .MEM_LAT(1), .HALT_OP(3'b111)) dut (
    .clock (clock),
    .resetN(resetN),
    .bus   (bus)
  );

  fetch_sequencer #(.ADDR_W(2), .DATA_W(16), .MEM_LAT(1), .HALT_OP(3'b111)) dut2 (
    .clock (clock),
    .resetN(resetN),
    .bus   (bus2)
  );

  // Synchronous ROMs, one cycle read latency.
  logic [15:0] rom  [32];
  logic [15:0] rom2 [4];
  always @(posedge clock) begin
    bus.mem_q  <= rom[bus.mem_addr];
    bus2.mem_q <= rom2[bus2.mem_addr];
  end

  // Processor model: proc_done arrives two cycles after each run pulse.
  logic [1:0] dsh  = '0;
  logic [1:0] dsh2 = '0;
  always @(posedge clock) begin
    dsh  <= {dsh[0], bus.run};
    dsh2 <= {dsh2[0], bus2.run};
  end
  assign bus.proc_done  = dsh[1];
  assign bus2.proc_done = dsh2[1];

  typedef struct {
    int          addr;
    logic [15:0] ins;
    int          cyc;
  } exp_t;
  exp_t q[$];
  exp_t q2[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Scoreboard monitors: each run pulse is matched against the next expectation.
  always @(negedge clock) begin
    if (resetN === 1'b1 && bus.run === 1'b1) begin
      if (q.size() == 0) begin
        chk("sb_run_without_expectation", 32'(q.size()), 32'd1);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("run_addr", 32'(bus.mem_addr), 32'(e.addr));
        chk("run_instr", 32'(bus.instr), 32'(e.ins));
        if (e.cyc >= 0) chk("run_latency", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  always @(negedge clock) begin
    if (resetN === 1'b1 && bus2.run === 1'b1) begin
      runs2 <= runs2 + 1;
      if (q2.size() == 0) begin
        chk("sb2_run_without_expectation", 32'(q2.size()), 32'd1);
      end else begin
        exp_t e;
        e = q2.pop_front();
        chk("wrap_addr", 32'(bus2.mem_addr), 32'(e.addr));
        chk("wrap_instr", 32'(bus2.instr), 32'(e.ins));
        if (e.cyc >= 0) chk("wrap_latency", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  task automatic wait_run(input int a, input int budget, input string nm);
    int n = 0;
    @(negedge clock);
    while (!(bus.run === 1'b1 && 32'(bus.mem_addr) == a) && n < budget) begin
      @(negedge clock);
      n++;
    end
    chk(nm, 32'(bus.run === 1'b1 && 32'(bus.mem_addr) == a), 32'd1);
  endtask

  task automatic wait_idle(input int budget, input string nm);
    int n = 0;
    @(negedge clock);
    while (bus.busy !== 1'b0 && n < budget) begin
      @(negedge clock);
      n++;
    end
    chk(nm, 32'(bus.busy), 32'd0);
  endtask

  task automatic do_reset();
    @(posedge clock);
    #1 resetN = 1'b0;
    #2 resetN = 1'b1;
    @(negedge clock);
  endtask

  task automatic pulse_start();
    @(posedge clock);
    #1;
    bus.start = 1'b1;
    @(posedge clock);
    #1;
    bus.start = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    resetN     = 1'b0;
    bus.start  = 1'b0;
    bus.stop   = 1'b0;
    bus2.start = 1'b0;
    bus2.stop  = 1'b0;
`ifdef FETCH_STEP_EN
    bus.step   = 1'b1;
    bus2.step  = 1'b1;
`endif
    for (int i = 0; i < 32; i++) rom[i] = 16'h0F00 + 16'(i);
    rom[0] = 16'h1000;
    rom[1] = 16'h2000;
    rom[2] = 16'hE000;
    rom2[0] = 16'h0100;
    rom2[1] = 16'h0201;
    rom2[2] = 16'h0302;
    rom2[3] = 16'h0403;

    // Reset state
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    chk("rst_instr", 32'(bus.instr), 32'd0);
    chk("rst_run", 32'(bus.run), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_halted", 32'(bus.halted), 32'd0);
    chk("rst_retired", 32'(bus.retired), 32'd0);
    resetN = 1'b1;

    // PC wrap with ADDR_W=2: addresses 0,1,2,3,0
    @(posedge clock);
    #1;
    for (int a = 0; a < 5; a++)
      q2.push_back('{a % 4, rom2[a % 4], (a == 0) ? cyc + 3 : -1});
    bus2.start = 1'b1;
    @(posedge clock);
    #1;
    bus2.start = 1'b0;
    begin
      int n = 0;
      while (runs2 < 5 && n < 200) begin
        @(negedge clock);
        n++;
      end
      chk("wrap_runs", 32'(runs2), 32'd5);
      bus2.stop = 1'b1;
      n = 0;
      @(negedge clock);
      while (bus2.busy !== 1'b0 && n < 50) begin
        @(negedge clock);
        n++;
      end
      bus2.stop = 1'b0;
      chk("wrap_idle_busy", 32'(bus2.busy), 32'd0);
      chk("wrap_retired", 32'(bus2.retired), 32'd5);
    end

    // stop held during EXEC of address 1
    @(posedge clock);
    #1;
    q.push_back('{0, 16'h1000, cyc + 3});
    q.push_back('{1, 16'h2000, -1});
    bus.start = 1'b1;
    @(posedge clock);
    #1;
    bus.start = 1'b0;
    wait_run(1, 100, "stop_reach_addr1");
    bus.stop = 1'b1;
    wait_idle(50, "stop_busy_low");
    bus.stop = 1'b0;
    chk("stop_retired", 32'(bus.retired), 32'd2);
    chk("stop_halted", 32'(bus.halted), 32'd0);

    // Restart from address 0 and run into the halt opcode at address 2
    @(posedge clock);
    #1;
    q.push_back('{0, 16'h1000, cyc + 3});
    q.push_back('{1, 16'h2000, -1});
    q.push_back('{2, 16'hE000, -1});
    bus.start = 1'b1;
    @(posedge clock);
    #1;
    bus.start = 1'b0;
    begin
      int n = 0;
      while (bus.halted !== 1'b1 && n < 200) begin
        @(negedge clock);
        n++;
      end
    end
    chk("halt_halted", 32'(bus.halted), 32'd1);
    chk("halt_busy", 32'(bus.busy), 32'd0);
    chk("halt_retired", 32'(bus.retired), 32'd5);

    // HALT ignores start and stop
    bus.start = 1'b1;
    bus.stop  = 1'b1;
    repeat (10) @(negedge clock);
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    chk("halt_sticky", 32'(bus.halted), 32'd1);
    chk("halt_addr", 32'(bus.mem_addr), 32'd2);
    chk("halt_sticky_busy", 32'(bus.busy), 32'd0);

    // Reset during EXEC; the late proc_done must not retire anything
    do_reset();
    chk("rst2_retired", 32'(bus.retired), 32'd0);
    chk("rst2_halted", 32'(bus.halted), 32'd0);
    @(posedge clock);
    #1;
    q.push_back('{0, 16'h1000, cyc + 3});
    bus.start = 1'b1;
    @(posedge clock);
    #1;
    bus.start = 1'b0;
    wait_run(0, 20, "abort_reach_run");
    @(posedge clock);
    #1 resetN = 1'b0;
    #1;
    chk("abort_instr", 32'(bus.instr), 32'd0);
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_run", 32'(bus.run), 32'd0);
    chk("abort_addr", 32'(bus.mem_addr), 32'd0);
    resetN = 1'b1;
    repeat (5) @(negedge clock);
    chk("abort_late_done_retired", 32'(bus.retired), 32'd0);
    chk("abort_late_done_busy", 32'(bus.busy), 32'd0);

`ifdef FETCH_STEP_EN
    // Single-step: park in PAUSE after the first retire until step
    bus.step = 1'b0;
    @(posedge clock);
    #1;
    q.push_back('{0, 16'h1000, cyc + 3});
    bus.start = 1'b1;
    @(posedge clock);
    #1;
    bus.start = 1'b0;
    wait_run(0, 20, "step_first_run");
    repeat (23) @(negedge clock);
    chk("step_pause_busy", 32'(bus.busy), 32'd1);
    chk("step_pause_addr", 32'(bus.mem_addr), 32'd0);
    chk("step_pause_retired", 32'(bus.retired), 32'd1);
    @(posedge clock);
    #1;
    q.push_back('{1, 16'h2000, cyc + 3});
    bus.step = 1'b1;
    @(posedge clock);
    #1;
    bus.step = 1'b0;
    wait_run(1, 20, "step_second_run");
    repeat (4) @(negedge clock);
    bus.stop = 1'b1;
    wait_idle(20, "step_stop_idle");
    bus.stop = 1'b0;
    bus.step = 1'b1;
    chk("step_retired", 32'(bus.retired), 32'd2);
`endif

    repeat (5) @(negedge clock);
    chk("sb_drain", 32'(q.size()), 32'd0);
    chk("sb2_drain", 32'(q2.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
